// File: rtl/keypad_scanner.sv
// ============================================================================
// Module   : keypad_scanner
// Brief    : 4x4 keypad column scanner and key-code encoder. A debounced
//            "any key down" level starts a column walk; the first low row
//            found is encoded as {row_idx, col_idx} and queued in a small
//            FIFO drained by a valid/ready consumer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_scanner #(
  parameter int SETTLE_CYC = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [3:0] row_n_i,
  input  logic       key_db_i,
  output logic [3:0] col_n_o,
  output logic [3:0] key_code_o,
  output logic       key_valid_o,
  input  logic       key_ready_i,
  output logic       overflow_o,
  input  logic       ovf_clr_i
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(SETTLE_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    HOLD   = 2'd3
  } state_e;

  state_e        state_q;
  logic [1:0]    col_idx_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    col_n_q;

  logic          row_hit;
  logic [1:0]    row_idx;
  logic          push;
  logic [3:0]    push_code;

  // Lowest-numbered low row wins when several rows read low together
  always_comb begin
    row_hit = (row_n_i != 4'hF);
    if (!row_n_i[0])      row_idx = 2'd0;
    else if (!row_n_i[1]) row_idx = 2'd1;
    else if (!row_n_i[2]) row_idx = 2'd2;
    else                  row_idx = 2'd3;
  end

  assign push      = (state_q == SAMPLE) && row_hit;
  assign push_code = {row_idx, col_idx_q};

  // Scan FSM: column drive is registered alongside the state it belongs to
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      col_idx_q <= 2'd0;
      cnt_q     <= '0;
      col_n_q   <= 4'b0000;
    end else begin
      case (state_q)
        IDLE: begin
          col_n_q <= 4'b0000;
          if (key_db_i) begin
            col_idx_q <= 2'd0;
            cnt_q     <= '0;
            col_n_q   <= 4'b1110;
            state_q   <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt_q == CNT_LAST) state_q <= SAMPLE;
          else                   cnt_q   <= cnt_q + CNT_ONE;
        end
        SAMPLE: begin
          // key_db is deliberately ignored here: a started scan always completes
          if (row_hit) begin
            col_n_q <= 4'b0000;
            state_q <= HOLD;
          end else if (col_idx_q != 2'd3) begin
            col_idx_q <= col_idx_q + 2'd1;
            cnt_q     <= '0;
            col_n_q   <= ~(4'b0001 << (col_idx_q + 2'd1));
            state_q   <= SETTLE;
          end else begin
            col_n_q <= 4'b0000;
            state_q <= IDLE;
          end
        end
        HOLD: begin
          col_n_q <= 4'b0000;
          if (!key_db_i) state_q <= IDLE;
        end
        default: begin
          col_n_q <= 4'b0000;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- FIFO ---
  logic [AW:0] wptr_q, rptr_q, wptr_d, rptr_d;
  logic [3:0]  mem_q [FIFO_DEPTH];
  logic [3:0]  key_code_q, head_d;
  logic        key_valid_q;
  logic        overflow_q;
  logic        fifo_full, pop, push_ok;

  // Pointer MSB separates full from empty; a pop frees room for a same-cycle push
  always_comb begin
    fifo_full = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    pop       = key_ready_i && key_valid_q;
    push_ok   = push && (!fifo_full || pop);
    wptr_d    = push_ok ? (wptr_q + PTR_ONE) : wptr_q;
    rptr_d    = pop     ? (rptr_q + PTR_ONE) : rptr_q;
    head_d    = key_code_q;
    if (wptr_d != rptr_d) begin
      // The new head may be the entry being written this very cycle
      if (push_ok && (wptr_q[AW-1:0] == rptr_d[AW-1:0])) head_d = push_code;
      else                                                head_d = mem_q[rptr_d[AW-1:0]];
    end
  end

  // Storage array needs no reset: pointers alone define what is valid
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q[AW-1:0]] <= push_code;
  end

  // Pointers, registered head/valid and the sticky overflow flag
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      key_code_q  <= head_d;
      key_valid_q <= (wptr_d != rptr_d);
      if (push && !push_ok) overflow_q <= 1'b1;
      else if (ovf_clr_i)   overflow_q <= 1'b0;
    end
  end

  assign col_n_o     = col_n_q;
  assign key_code_o  = key_code_q;
  assign key_valid_o = key_valid_q;
  assign overflow_o  = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_keypad_scanner.sv
// ============================================================================
// Module   : tb_keypad_scanner
// Brief    : Directed self-checking bench for keypad_scanner with a simple
//            resistive-matrix keypad model driving row_n from col_n.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] row_n;
  logic       key_db;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       overflow;
  logic       ovf_clr;

  logic       pressed;
  logic [1:0] key_r, key_c;

  int checks = 0;
  int errors = 0;
  logic [3:0] got_q[$];

  always #5 clk = ~clk;

  // Keypad model: the pressed key pulls its row low while its column is driven
  assign row_n = (pressed && !col_n[key_c]) ? ~(4'b0001 << key_r) : 4'hF;

  keypad_scanner #(.SETTLE_CYC(16), .FIFO_DEPTH(4)) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .row_n_i    (row_n),
    .key_db_i   (key_db),
    .col_n_o    (col_n),
    .key_code_o (key_code),
    .key_valid_o(key_valid),
    .key_ready_i(key_ready),
    .overflow_o (overflow),
    .ovf_clr_i  (ovf_clr)
  );

  // Record every code actually handed over (valid & ready before the edge)
  always @(negedge clk) begin
    #1;
    if (!reset && key_valid && key_ready) got_q.push_back(key_code);
  end

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; key_db = 1'b0; pressed = 1'b0; key_ready = 1'b0; ovf_clr = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    got_q.delete();
  endtask

  // One press (or a one-cycle spurious key_db pulse); cyc = negedges until col_n returns to 0
  task automatic press(input logic [1:0] r, input logic [1:0] c, input bit spur,
                       output int cyc, output int vcyc);
    bit started, onehot_ok, hold_ok;
    @(negedge clk);
    key_r = r; key_c = c; pressed = !spur; key_db = 1'b1;
    cyc = 0; vcyc = -1; started = 0; onehot_ok = 1;
    while (cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (spur) key_db = 1'b0;
      if (vcyc < 0 && key_valid) vcyc = cyc;
      if (col_n != 4'b0000) begin
        started = 1;
        if ($countones(~col_n) != 1) onehot_ok = 0;
      end else if (started) begin
        break;
      end
    end
    checks++;
    if (!started || cyc >= 200) begin
      errors++; $display("FAIL scan_done: started=%0d cycles=%0d required completion", started, cyc);
    end
    checks++;
    if (!onehot_ok) begin
      errors++; $display("FAIL col_onehot: col_n not one-hot-low during scan (key %0d,%0d)", r, c);
    end
    if (!spur) begin
      hold_ok = 1;
      repeat (3) begin
        @(negedge clk);
        if (col_n !== 4'b0000) hold_ok = 0;
      end
      checks++;
      if (!hold_ok) begin
        errors++; $display("FAIL hold_col: col_n=%b while held, required 0000", col_n);
      end
    end
    key_db = 1'b0; pressed = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (col_n !== 4'b0000) begin errors++; $display("FAIL rst_col_n: got %b required 0000", col_n); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b required 0", key_valid); end
    checks++; if (key_code !== 4'h0) begin errors++; $display("FAIL rst_code: got %h required 0", key_code); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b required 0", overflow); end
  endtask

  task automatic test_basic_press();
    int cyc, vcyc;
    apply_reset();
    press(2'd2, 2'd1, 0, cyc, vcyc);
    checks++; if (cyc != 35) begin errors++; $display("FAIL basic_hold_time: got %0d required 35", cyc); end
    checks++; if (vcyc != 35) begin errors++; $display("FAIL basic_valid_time: got %0d required 35", vcyc); end
    checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b required 1", key_valid); end
    checks++; if (key_code !== 4'h9) begin errors++; $display("FAIL basic_code: got %h required 9", key_code); end
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL basic_pop: got %b required 0", key_valid); end
  endtask

  task automatic test_sweep();
    int cyc, vcyc;
    logic [3:0] exp;
    apply_reset();
    key_ready = 1'b1;
    for (int k = 0; k < 16; k++) press(2'(k >> 2), 2'(k & 3), 0, cyc, vcyc);
    key_ready = 1'b0;
    checks++;
    if (got_q.size() != 16) begin errors++; $display("FAIL sweep_count: got %0d required 16", got_q.size()); end
    for (int k = 0; k < 16 && k < got_q.size(); k++) begin
      exp = 4'(k);
      checks++;
      if (got_q[k] !== exp) begin errors++; $display("FAIL sweep_code[%0d]: got %h required %h", k, got_q[k], exp); end
    end
  endtask

  task automatic test_spurious();
    int cyc, vcyc;
    apply_reset();
    press(2'd0, 2'd0, 1, cyc, vcyc);
    checks++; if (cyc != 69) begin errors++; $display("FAIL spur_time: got %0d required 69", cyc); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL spur_push: key_valid got %b required 0", key_valid); end
    checks++; if (col_n !== 4'b0000) begin errors++; $display("FAIL spur_idle: col_n got %b required 0000", col_n); end
  endtask

  task automatic test_overflow();
    int cyc, vcyc;
    logic [3:0] exp_q[$];
    apply_reset();
    exp_q = '{4'h3, 4'h6, 4'h9, 4'hC};
    press(2'd0, 2'd3, 0, cyc, vcyc);
    press(2'd1, 2'd2, 0, cyc, vcyc);
    press(2'd2, 2'd1, 0, cyc, vcyc);
    press(2'd3, 2'd0, 0, cyc, vcyc);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_at4: got %b required 0", overflow); end
    press(2'd3, 2'd3, 0, cyc, vcyc);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_at5: got %b required 1", overflow); end
    checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid: got %b required 1", key_valid); end
    checks++; if (key_code !== 4'h3) begin errors++; $display("FAIL ovf_head: got %h required 3", key_code); end
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b required 0", overflow); end
    got_q.delete();
    key_ready = 1'b1;
    repeat (6) @(negedge clk);
    key_ready = 1'b0;
    checks++;
    if (got_q.size() != 4) begin errors++; $display("FAIL ovf_drain_count: got %0d required 4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_drain[%0d]: got %h required %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty: got %b required 0", key_valid); end
  endtask

  task automatic test_full_push_pop();
    int cyc, vcyc;
    logic [3:0] exp_q[$];
    apply_reset();
    exp_q = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h5};
    press(2'd0, 2'd1, 0, cyc, vcyc);
    press(2'd0, 2'd2, 0, cyc, vcyc);
    press(2'd1, 2'd0, 0, cyc, vcyc);
    press(2'd2, 2'd0, 0, cyc, vcyc);
    got_q.delete();
    @(negedge clk);
    key_r = 2'd1; key_c = 2'd1; pressed = 1'b1; key_db = 1'b1;
    repeat (34) @(negedge clk);
    // Now in the SAMPLE cycle of column 1: push and pop share the next edge
    checks++; if (col_n !== 4'b1101) begin errors++; $display("FAIL fpp_sample_col: got %b required 1101", col_n); end
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_ovf: got %b required 0", overflow); end
    checks++; if (col_n !== 4'b0000) begin errors++; $display("FAIL fpp_hold: got %b required 0000", col_n); end
    key_db = 1'b0; pressed = 1'b0;
    repeat (2) @(negedge clk);
    key_ready = 1'b1;
    repeat (6) @(negedge clk);
    key_ready = 1'b0;
    checks++;
    if (got_q.size() != 5) begin errors++; $display("FAIL fpp_count: got %0d required 5", got_q.size()); end
    for (int i = 0; i < 5 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL fpp_drain[%0d]: got %h required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_scan();
    int cyc, vcyc, n;
    apply_reset();
    press(2'd1, 2'd3, 0, cyc, vcyc);
    press(2'd2, 2'd2, 0, cyc, vcyc);
    @(negedge clk);
    key_r = 2'd3; key_c = 2'd3; pressed = 1'b1; key_db = 1'b1;
    n = 0;
    while (n < 100 && col_n !== 4'b1011) begin
      @(negedge clk);
      n++;
    end
    checks++; if (col_n !== 4'b1011) begin errors++; $display("FAIL mid_reach_col2: got %b required 1011", col_n); end
    repeat (3) @(negedge clk);
    reset = 1'b1; key_db = 1'b0; pressed = 1'b0;
    @(negedge clk);
    checks++; if (col_n !== 4'b0000) begin errors++; $display("FAIL mid_col_n: got %b required 0000", col_n); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b required 0", key_valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mid_ovf: got %b required 0", overflow); end
    checks++; if (key_code !== 4'h0) begin errors++; $display("FAIL mid_code: got %h required 0", key_code); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (col_n !== 4'b0000 || key_valid !== 1'b0) begin
      errors++; $display("FAIL mid_idle: col_n=%b valid=%b required 0000/0", col_n, key_valid);
    end
  endtask

  initial begin
    reset = 1'b1; key_db = 1'b0; pressed = 1'b0; key_ready = 1'b0; ovf_clr = 1'b0;
    key_r = 2'd0; key_c = 2'd0;
    test_reset();
    test_basic_press();
    test_sweep();
    test_spurious();
    test_overflow();
    test_full_push_pop();
    test_reset_mid_scan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/keypad_scanner.md
# keypad_scanner

Matrix scan and key-code encoder for the 4x4 keypad in the wb_keyboard path. It sits directly downstream of the keypad debounce stage and consumes its debounced "any key down" level. On each debounced press it walks the columns to locate the key and encodes it as a 4-bit code. The code is queued in a small FIFO that the Wishbone register front end drains through a valid/ready handshake.

## Interface
- SETTLE_CYC, 16: clock cycles each column is driven before rows are sampled (≥2).
- FIFO_DEPTH, 4: key-code FIFO entries; power of two, ≥2.
- clk  in  1  system clock; everything below is synchronous to its rising edge.
- reset  in  1  synchronous, active-high reset.
- row_n  in  4  raw keypad rows, active-low. Already two-flop synchronized upstream.
- key_db  in  1  debounced "any key down" from the debounce stage, active-high.
- col_n  out  4  column drives, active-low.
- key_code  out  4  head-of-FIFO code = {row_idx[1:0], col_idx[1:0]}.
- key_valid  out  1  FIFO not empty.
- key_ready  in  1  consumer accepts key_code when key_valid & key_ready.
- overflow  out  1  sticky: a press was lost because the FIFO was full.
- ovf_clr  in  1  clears overflow.

## Operation
- FSM states: IDLE, SETTLE, SAMPLE, HOLD.
- IDLE
  - col_n = 4'b0000 (all columns driven).
  - On key_db = 1: col_idx ← 0, settle counter ← 0, go to SETTLE.
- SETTLE
  - col_n drives only col_idx low; the other columns are 1.
  - The counter increments each cycle. When it reaches SETTLE_CYC-1, go to SAMPLE.
- SAMPLE (one cycle, same col_n as SETTLE)
  - If row_n ≠ 4'hF: row_idx = lowest index with row_n[i] = 0. Push {row_idx, col_idx} into the FIFO, go to HOLD.
  - Else, if col_idx < 3: col_idx+1, counter ← 0, go to SETTLE.
  - Else (no key found in any column): go to IDLE. This is a spurious event; nothing is pushed.
- HOLD
  - col_n = 4'b0000.
  - Stay until key_db = 0, then go to IDLE.
  - Exactly one code is pushed per debounced press; there is no auto-repeat.
- key_db falling during SETTLE or SAMPLE does not abort the scan: the scan completes, and the result is pushed if a row is low.
- FIFO
  - Pointers are log2(FIFO_DEPTH)+1 bits; the MSB distinguishes full from empty.
  - key_code is the registered head entry; it is valid whenever key_valid = 1.
  - Push when full: the code is dropped, the FIFO contents are unchanged, and overflow ← 1.
  - Push and pop in the same cycle while full: the pop happens first, the push is accepted, and overflow is not set.
  - Push and pop in the same cycle while empty: the push is accepted, the pop is ignored (key_valid was 0).
- overflow
  - Set by a dropped push, cleared by ovf_clr.
  - If both occur in the same cycle, set wins.

## Timing
- Reset values: state IDLE, col_n = 4'b0000, key_valid = 0, key_code = 4'h0, overflow = 0, FIFO empty.
- reset asserted mid-scan or in HOLD returns to IDLE on the next edge and flushes the FIFO.
- IDLE→SETTLE takes 1 cycle after key_db is seen high.
- Each column occupies SETTLE_CYC + 1 cycles (SETTLE plus SAMPLE).
- A key in column c is pushed at the SAMPLE edge, (c+1)·(SETTLE_CYC+1) cycles after leaving IDLE.
- key_valid rises the cycle after the push edge. Push-to-output latency is 1 cycle.
- key_valid falls the cycle after the pop of the last entry.
- col_n and all outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Basic press.** Reset, then press row 2 / col 1 (key_db high, row_n[2] = 0 only while col_n[1] = 0). Required: one push, key_code = 4'h9, key_valid rises 2·17+1 cycles after key_db. key_ready = 1 then drops key_valid the next cycle.
- **Full sweep.** Press all 16 keys in sequence with key_ready = 1. Required: codes 0x0…0xF in order, each exactly once. col_n is 4'b0000 in IDLE and HOLD, and one-hot-low during the scan.
- **Spurious event.** key_db pulses high while row_n stays 4'hF. Required: 4 columns are scanned, the FSM returns to IDLE after 4·17 cycles, nothing is pushed.
- **Overflow.** Issue 5 presses with key_ready = 0. Required: key_valid = 1, the FIFO holds the first 4 codes, overflow = 1 after the 5th. ovf_clr pulse → overflow = 0. Then draining returns the first 4 codes in order.
- **Simultaneous full push/pop.** With the FIFO full, push a new code in the same cycle as key_ready = 1. Required: overflow stays 0, the new code becomes the last entry.
- **Reset mid-scan.** Assert reset during SETTLE of col 2 with 2 codes queued. Required: next cycle state is IDLE, col_n = 4'b0000, key_valid = 0, overflow = 0.
